// File: rtl/result_tx_pkg.sv
// Shared types and constants for the result line transmitter.
// Holds the transmit FSM state type, the three ASCII characters the
// block emits, and a helper that maps a data bit to its character.
package result_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    LF   = 2'd2
  } tx_state_t;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  function automatic logic [7:0] bit_char(input logic b);
    return b ? CHAR_1 : CHAR_0;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with first-word-visible read.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   push, din    : write din when push && !full
//   pop          : advance the head when pop && !empty
//   dout         : current head word (valid while !empty)
//   full, empty  : occupancy flags
// Pointers carry one extra bit so full and empty differ at wrap-around.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // Storage needs no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/result_line_tx.sv
// Result line transmitter: turns each WORD_W-bit result word into one
// ASCII line of '0'/'1' characters, MSB first, terminated by LF.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid, in_ready, in_data   : word input handshake (into the FIFO)
//   out_valid, out_ready, out_byte: byte output handshake (registered)
//   busy                          : FSM active or words still queued
//   words_sent                    : lines whose LF was accepted (wraps)
module result_line_tx
  import result_tx_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_W-1);

  tx_state_t         state, state_n;
  logic [WORD_W-1:0] sh, sh_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_m1;
  logic              ov_n;
  logic [7:0]        ob_n;
  logic              pop, sent_inc;
  logic [WORD_W-1:0] head;
  logic              full, empty;

  word_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;
  assign idx_m1   = idx - IDX_W'(1);

  // out_valid/out_byte are computed one cycle ahead so the output pins
  // come straight from flops and hold still during a stall.
  always_comb begin
    state_n  = state;
    sh_n     = sh;
    idx_n    = idx;
    ov_n     = out_valid;
    ob_n     = out_byte;
    pop      = 1'b0;
    sent_inc = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = head;
          idx_n   = IDX_MAX;
          state_n = BITS;
          ov_n    = 1'b1;
          ob_n    = bit_char(head[WORD_W-1]);
        end
      end
      BITS: begin
        if (out_ready) begin
          if (idx == '0) begin
            state_n = LF;
            ob_n    = CHAR_LF;
          end else begin
            idx_n = idx_m1;
            ob_n  = bit_char(sh[idx_m1]);
          end
        end
      end
      LF: begin
        if (out_ready) begin
          sent_inc = 1'b1;
          if (!empty) begin
            // Chain straight into the next line without an idle cycle.
            pop     = 1'b1;
            sh_n    = head;
            idx_n   = IDX_MAX;
            state_n = BITS;
            ob_n    = bit_char(head[WORD_W-1]);
          end else begin
            state_n = IDLE;
            ov_n    = 1'b0;
            ob_n    = 8'h00;
          end
        end
      end
      default: begin
        state_n = IDLE;
        ov_n    = 1'b0;
        ob_n    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sh         <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_byte   <= 8'h00;
      words_sent <= '0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      idx       <= idx_n;
      out_valid <= ov_n;
      out_byte  <= ob_n;
      if (sent_inc) words_sent <= words_sent + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_result_line_tx.sv
// Scoreboard bench for result_line_tx: expected characters are queued
// when a word is accepted and compared as bytes are handshaked out.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_result_line_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        busy;
  logic [15:0] words_sent;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [7:0]  w_out_byte;
  logic        w_busy;
  logic [1:0]  w_words_sent;

  always #5 clk = ~clk;

  result_line_tx u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .busy(busy), .words_sent(words_sent)
  );

  result_line_tx #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_byte(w_out_byte),
    .busy(w_busy), .words_sent(w_words_sent)
  );

  int         errors = 0;
  int         checks = 0;
  int         byte_cnt = 0;
  int         exp_sent = 0;
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_chars(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i] ? 8'h31 : 8'h30);
    exp_q.push_back(8'h0A);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    check("push_accept", 32'(acc), 1);
    if (acc) push_chars(w);
    in_valid = 1'b0;
  endtask

  // Drive out_ready with a repeating 4-cycle pattern until all expected
  // bytes are out and the DUT is idle.
  task automatic drain(input logic [3:0] pat, input int limit);
    int k;
    bit done;
    k = 0;
    done = 1'b0;
    while (k < limit) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      out_ready = pat[k % 4];
      k++;
    end
    check("drain_done", 32'(done), 1);
    out_ready = 1'b1;
  endtask

  // Output monitor: scoreboard compare on every handshake, stability
  // check on every stalled cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_byte", 32'(out_byte), 32'(prev_byte));
        end
        if (out_valid && out_ready) begin
          check("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("byte", 32'(out_byte), 32'(exp_q.pop_front()));
          byte_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] words[6];
  int          cnt, base, n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_byte", 32'(out_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_words_sent", 32'(words_sent), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word, latency and completion
    push_word(32'h0003C99B);
    check("lat_edge_n", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_edge_n1", 32'(out_valid), 1);
    check("first_byte", 32'(out_byte), 32'h30);
    drain(4'b1111, 200);
    exp_sent = 1;
    check("single_sent", 32'(words_sent), 32'(exp_sent));
    check("single_busy", 32'(busy), 0);

    // Backpressure: ready pattern 1,0,0,1
    push_word(32'h0003C99B);
    drain(4'b1001, 400);
    exp_sent++;
    check("bp_sent", 32'(words_sent), 32'(exp_sent));

    // Full FIFO: one word in the shift register plus DEPTH queued
    words = '{32'h11111111, 32'h80000000, 32'h0000FFFF, 32'hDEADBEEF, 32'h00000001, 32'hCAFEF00D};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(words[i]);
    check("full_in_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = words[5];
    repeat (3) begin
      @(negedge clk);
      check("full_held", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    fork
      push_word(words[5]);
      drain(4'b1111, 600);
    join
    exp_sent += 6;
    check("full_sent", 32'(words_sent), 32'(exp_sent));

    // Back-to-back lines with no bubble
    out_ready = 1'b0;
    push_word(32'hFFFFFFFF);
    push_word(32'h00000000);
    push_word(32'h80000001);
    out_ready = 1'b1;
    cnt = 0;
    repeat (99) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("b2b_valid_run", 32'(cnt), 99);
    @(negedge clk);
    check("b2b_end", 32'(out_valid), 0);
    drain(4'b1111, 50);
    exp_sent += 3;
    check("b2b_sent", 32'(words_sent), 32'(exp_sent));

    // Reset in the middle of a line, with another word still queued
    out_ready = 1'b1;
    push_word(32'hA5A5F00F);
    push_word(32'h5A5A0FF0);
    base = byte_cnt - 1;  // first byte of the line was already counted
    n = 0;
    while (byte_cnt < base + 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_bytes", 32'(byte_cnt - base), 10);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rstmid_out_valid", 32'(out_valid), 0);
    check("rstmid_words_sent", 32'(words_sent), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_sent = 0;
    push_word(32'h12345678);
    drain(4'b1111, 200);
    exp_sent = 1;
    check("rstmid_fresh_sent", 32'(words_sent), 32'(exp_sent));

    // Random words under irregular backpressure
    fork
      for (int i = 0; i < 6; i++) push_word($urandom);
      drain(4'b1101, 1500);
    join
    exp_sent += 6;
    check("rand_sent", 32'(words_sent), 32'(exp_sent));

    // Counter wrap on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      w_in_valid = 1'b1;
      w_in_data  = $urandom;
      @(posedge clk); #1;
      w_in_valid = 1'b0;
      n = 0;
      while (w_busy && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("wrap_cnt", 32'(w_words_sent), 32'((i + 1) % 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_line_tx.md
Name: result_line_tx

Overview:
- Writer counterpart to the binary-text sample loader used around Modelado: takes 32-bit result words from the datapath and emits each as one ASCII line of '0'/'1' characters, MSB first, terminated by LF.
- The output is exactly the line format consumed by the loader (one 32-char binary word per line).
- Sits between the Modelado result path and a byte sink (UART TX or file-capture monitor).
- Small word FIFO absorbs bursts; byte-level valid/ready output.

Parameters:
- WORD_W, 32, width of each result word and number of characters per line
- DEPTH, 4, FIFO depth in words (power of two, >=2)
- CNT_W, 16, width of the words_sent counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  result word offered
- in_ready  output  1  FIFO can accept a word this cycle
- in_data  input  WORD_W  result word
- out_valid  output  1  out_byte is valid
- out_ready  input  1  sink accepts out_byte this cycle
- out_byte  output  8  ASCII character: 8'h30, 8'h31 or 8'h0A
- busy  output  1  FSM not IDLE or FIFO non-empty
- words_sent  output  CNT_W  count of lines whose LF has been accepted

Behaviour:
- Reset (rst=1 at a clock edge): FIFO emptied, FSM=IDLE, out_valid=0, out_byte=8'h00, busy=0, words_sent=0, in_ready=1 from the following cycle. Reset mid-line drops the partial line and all queued words; no LF is emitted.
- Input handshake: word is written when in_valid && in_ready. in_ready = !fifo_full. No pass-through when full.
- Same-cycle push and pop with FIFO neither full nor empty: occupancy is unchanged.
- FSM states:
  - IDLE: out_valid=0. If FIFO non-empty, pop the head into shift register sh, set bit index idx=WORD_W-1, go to BITS.
  - BITS: out_valid=1, out_byte = sh[idx] ? 8'h31 : 8'h30. On out_ready: if idx==0 go to LF, else idx--.
  - LF: out_valid=1, out_byte=8'h0A. On out_ready: words_sent++. Then, if FIFO is non-empty, pop the head, load sh, set idx=WORD_W-1 and go to BITS (no bubble between lines); otherwise go to IDLE.
- Output stability: out_byte and out_valid are registered and held unchanged while out_valid && !out_ready.
- out_valid never drops without a handshake, except on reset.
- Latency:
  - A word pushed at edge N into an empty FIFO with the FSM in IDLE gives out_valid=1 after edge N+1.
  - One line is WORD_W+1 bytes. Throughput is one byte per cycle at out_ready=1.
- Counter: words_sent wraps modulo 2^CNT_W with no saturation.
- busy is combinational from state and FIFO occupancy.

Decomposition:
- Package result_tx_pkg:
  - state enum tx_state_t {IDLE, BITS, LF}
  - constants CHAR_0=8'h30, CHAR_1=8'h31, CHAR_LF=8'h0A
- Sub-module word_fifo (WIDTH, DEPTH):
  - synchronous FIFO with push/pop, full/empty and first-word-visible read (dout = head)
  - pointer width $clog2(DEPTH)+1 so full and empty are distinguished at wrap-around

Test Plan:
- Single word: push 32'h0003C99B, out_ready=1 -> 33 consecutive bytes forming "00000000000000111100100110011011\n", first valid 2 edges after push; then words_sent=1, busy=0.
- Backpressure: same word, out_ready toggling 1,0,0,1 repeating -> identical 33-byte sequence, out_byte stable during every stall, no byte lost or duplicated.
- Full FIFO: out_ready=0, offer 6 words back-to-back (DEPTH=4).
  - in_ready falls after the 5th accepted word: 1 word sits in the shift register, 4 in the FIFO.
  - 6th word held until a pop.
  - Releasing out_ready then yields all 6 lines in order.
- Back-to-back: 3 words 32'hFFFFFFFF, 32'h00000000, 32'h80000001 queued, out_ready=1 -> 99 contiguous valid cycles, with LF at byte indices 32, 65 and 98.
- Reset mid-line: assert rst after 10 bytes of a line -> next cycle out_valid=0, words_sent=0, FIFO empty; a new word then produces a complete fresh line.
- Counter wrap: CNT_W=2, send 5 words -> words_sent reads 1,2,3,0,1.
